// File: rtl/jogo_playseq_n.sv
// jogo_playseq_n: memory game engine that grows an LFSR-generated sequence by one step per round
//   clock     rising-edge clock
//   reset     synchronous, active-low
//   jogar     start request (honoured in INICIAL and the end states)
//   botoes    debounced buttons, active-high
//   semente   LFSR seed (0 selects 8'h01)
//   ganhou/perdeu/timeout/pronto  end-of-game flags
//   leds      preview LEDs, or an echo of the registered buttons while waiting for a move
//   rodada    current sequence length
//   db_vidas  remaining lives
//   db_estado state code
module jogo_playseq_n #(
   parameter int N_BOTOES       = 4,
   parameter int MAX_SEQ        = 16,
   parameter int LED_CICLOS     = 1000,
   parameter int GAP_CICLOS     = 500,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int VIDAS          = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic [7:0]          semente,
   output logic                ganhou,
   output logic                perdeu,
   output logic                timeout,
   output logic                pronto,
   output logic [N_BOTOES-1:0] leds,
   output logic [5:0]          rodada,
   output logic [2:0]          db_vidas,
   output logic [3:0]          db_estado
);
   localparam int SW   = $clog2(N_BOTOES);
   localparam int IW   = MAX_SEQ > 1 ? $clog2(MAX_SEQ) : 1;
   localparam int MC1  = LED_CICLOS > GAP_CICLOS ? LED_CICLOS : GAP_CICLOS;
   localparam int MAXC = MC1 > TIMEOUT_CICLOS ? MC1 : TIMEOUT_CICLOS;
   localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARA        = 4'h1,
      GERA           = 4'h2,
      MOSTRA_ACESO   = 4'h3,
      MOSTRA_APAGADO = 4'h4,
      ESPERA         = 4'h5,
      COMPARA        = 4'h6,
      FIM_GANHOU     = 4'hA,
      FIM_PERDEU     = 4'hB,
      FIM_TIMEOUT    = 4'hC
   } estado_t;

   estado_t             estado, prox;
   logic [SW-1:0]       seq [MAX_SEQ];
   logic [IW-1:0]       idx;
   logic [5:0]          rod;
   logic [2:0]          vidas;
   logic [TW-1:0]       cnt;
   logic [7:0]          lfsr;
   logic [N_BOTOES-1:0] botoes_reg, botoes_ant, jogada, alvo;
   logic                press, acerto, ultimo, temporizado, fim_led, fim_gap, fim_tempo;

   assign alvo        = {{(N_BOTOES-1){1'b0}}, 1'b1} << seq[idx];
   // only a transition from all-released counts, so a held button never repeats
   assign press       = botoes_ant == '0 && botoes_reg != '0;
   // a multi-bit move can never equal the one-hot target, so it is wrong by construction
   assign acerto      = jogada == alvo;
   assign ultimo      = 6'(idx) == rod - 6'd1;
   assign temporizado = estado inside {MOSTRA_ACESO, MOSTRA_APAGADO, ESPERA};
   assign fim_led     = cnt == TW'(LED_CICLOS - 1);
   assign fim_gap     = cnt == TW'(GAP_CICLOS - 1);
   assign fim_tempo   = cnt == TW'(TIMEOUT_CICLOS - 1);

   always_ff @(posedge clock)
      if (!reset) estado <= INICIAL;
      else        estado <= prox;

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:        if (jogar) prox = PREPARA;
         PREPARA:        prox = GERA;
         GERA:           prox = MOSTRA_ACESO;
         MOSTRA_ACESO:   if (fim_led) prox = MOSTRA_APAGADO;
         MOSTRA_APAGADO: if (fim_gap) prox = ultimo ? ESPERA : MOSTRA_ACESO;
         // a press on the last timer cycle takes priority over the timeout
         ESPERA:         prox = press ? COMPARA : fim_tempo ? FIM_TIMEOUT : ESPERA;
         COMPARA:        prox = !acerto ? (vidas == 3'd1 ? FIM_PERDEU : MOSTRA_ACESO) :
                                !ultimo ? ESPERA :
                                rod == 6'(MAX_SEQ) ? FIM_GANHOU : GERA;
         FIM_GANHOU,
         FIM_PERDEU,
         FIM_TIMEOUT:    if (jogar) prox = PREPARA;
         default:        prox = INICIAL;
      endcase
   end

   always_comb begin
      leds      = estado == MOSTRA_ACESO ? alvo : estado == ESPERA ? botoes_reg : '0;
      ganhou    = estado == FIM_GANHOU;
      perdeu    = estado == FIM_PERDEU;
      timeout   = estado == FIM_TIMEOUT;
      pronto    = estado inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
      rodada    = rod;
      db_vidas  = vidas;
      db_estado = estado;
   end

   always_ff @(posedge clock)
      if (!reset) begin
         botoes_reg <= '0;
         botoes_ant <= '0;
         jogada     <= '0;
         cnt        <= '0;
         lfsr       <= '0;
         rod        <= '0;
         vidas      <= '0;
         idx        <= '0;
      end else begin
         botoes_reg <= botoes;
         botoes_ant <= botoes_reg;
         // shared timer restarts on every state change and only runs in timed states
         cnt        <= (prox != estado || !temporizado) ? '0 : cnt + 1'b1;
         case (estado)
            PREPARA: begin
               lfsr  <= semente == 8'h00 ? 8'h01 : semente;
               rod   <= '0;
               vidas <= 3'(VIDAS);
               idx   <= '0;
            end
            GERA: begin
               lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               rod  <= rod + 6'd1;
               idx  <= '0;
            end
            MOSTRA_APAGADO: if (fim_gap) idx <= ultimo ? '0 : idx + 1'b1;
            ESPERA:         if (press) jogada <= botoes_reg;
            COMPARA:
               if (!acerto) begin
                  vidas <= vidas - 3'd1;
                  idx   <= '0;
               end else if (!ultimo) idx <= idx + 1'b1;
            default: ;
         endcase
      end

   always_ff @(posedge clock)
      if (estado == GERA) seq[rod[IW-1:0]] <= SW'(lfsr % 8'(N_BOTOES));
endmodule

// File: tb/tb_jogo_playseq_n.sv
// tb_jogo_playseq_n: directed self-checking bench for jogo_playseq_n
module tb_jogo_playseq_n;
   logic       clock = 1'b0;
   logic       reset, jogar;
   logic [3:0] botoes;
   logic [7:0] semente;
   logic       ganhou, perdeu, timeout, pronto;
   logic [3:0] leds;
   logic [5:0] rodada;
   logic [2:0] db_vidas;
   logic [3:0] db_estado;
   int         passed = 0;
   int         total  = 0;

   jogo_playseq_n #(
      .N_BOTOES(4), .MAX_SEQ(3), .LED_CICLOS(4), .GAP_CICLOS(2), .TIMEOUT_CICLOS(20), .VIDAS(2)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .semente(semente),
      .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
      .leds(leds), .rodada(rodada), .db_vidas(db_vidas), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic jog(input logic [3:0] b);
      botoes = b;
      tick(1);
      botoes = 4'b0000;
      tick(2);
   endtask

   task automatic wait_st(input logic [3:0] s, input int lim, input string tag);
      int n = 0;
      while (db_estado !== s && n < lim) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(db_estado), 32'(s));
   endtask

   task automatic start();
      jogar = 1'b1;
      tick(1);
      jogar = 1'b0;
   endtask

   initial begin
      reset = 1'b0; jogar = 1'b0; botoes = 4'b0000; semente = 8'h00;
      tick(3);
      chk("rst_estado", 32'(db_estado), 'h0);
      chk("rst_leds", 32'(leds), 'h0);
      chk("rst_rodada", 32'(rodada), 'h0);
      chk("rst_vidas", 32'(db_vidas), 'h0);
      chk("rst_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h0);
      reset = 1'b1;
      tick(2);
      chk("idle", 32'(db_estado), 'h0);

      // seed 0 -> LFSR 01,02,04 -> sequence 1,2,0
      start();
      chk("prepara", 32'(db_estado), 'h1);
      tick(1);
      chk("gera", 32'(db_estado), 'h2);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("prev_on", 32'(leds), 'h2);
      end
      for (int i = 0; i < 2; i++) begin
         tick(1);
         chk("prev_off", 32'(leds), 'h0);
      end
      tick(1);
      chk("espera1", 32'(db_estado), 'h5);
      chk("rodada1", 32'(rodada), 'h1);
      chk("vidas_ini", 32'(db_vidas), 'h2);

      botoes = 4'b0010;
      tick(1);
      chk("echo", 32'(leds), 'h2);
      chk("still_espera", 32'(db_estado), 'h5);
      botoes = 4'b0000;
      tick(1);
      chk("compara", 32'(db_estado), 'h6);
      tick(1);
      chk("r1_gera", 32'(db_estado), 'h2);
      wait_st(4'h5, 60, "r2_espera");
      chk("rodada2", 32'(rodada), 'h2);
      jog(4'b0010);
      chk("r2_m1", 32'(db_estado), 'h5);
      jog(4'b0100);
      chk("r2_gera", 32'(db_estado), 'h2);
      wait_st(4'h5, 80, "r3_espera");
      chk("rodada3", 32'(rodada), 'h3);
      jog(4'b0010);
      jog(4'b0100);
      jog(4'b0001);
      chk("win_estado", 32'(db_estado), 'hA);
      chk("win_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h9);
      chk("win_rodada", 32'(rodada), 'h3);
      tick(100);
      chk("win_hold", 32'(db_estado), 'hA);
      chk("win_hold_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h9);
      chk("win_hold_leds", 32'(leds), 'h0);

      // life loss and replay
      start();
      chk("lose_prepara", 32'(db_estado), 'h1);
      chk("lose_flags_clr", 32'({ganhou, perdeu, timeout, pronto}), 'h0);
      wait_st(4'h5, 60, "lose_r1");
      jog(4'b0010);
      wait_st(4'h5, 80, "lose_r2");
      chk("lose_vidas2", 32'(db_vidas), 'h2);
      jog(4'b0001);
      chk("replay_estado", 32'(db_estado), 'h3);
      chk("replay_vidas", 32'(db_vidas), 'h1);
      chk("replay_rodada", 32'(rodada), 'h2);
      chk("replay_led0", 32'(leds), 'h2);
      tick(6);
      chk("replay_led1", 32'(leds), 'h4);
      tick(6);
      chk("replay_espera", 32'(db_estado), 'h5);
      chk("replay_rodada2", 32'(rodada), 'h2);
      jog(4'b0011);
      chk("lost_estado", 32'(db_estado), 'hB);
      chk("lost_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h5);
      chk("lost_vidas", 32'(db_vidas), 'h0);

      // timeout exactly 20 cycles after entering ESPERA
      start();
      wait_st(4'h5, 60, "to_espera");
      tick(19);
      chk("to_not_yet", 32'(db_estado), 'h5);
      tick(1);
      chk("to_estado", 32'(db_estado), 'hC);
      chk("to_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h3);

      // press on the last timer cycle wins over the timeout
      start();
      wait_st(4'h5, 60, "race_espera");
      tick(18);
      botoes = 4'b0010;
      tick(1);
      chk("race_espera2", 32'(db_estado), 'h5);
      botoes = 4'b0000;
      tick(1);
      chk("race_compara", 32'(db_estado), 'h6);
      tick(1);
      chk("race_gera", 32'(db_estado), 'h2);

      // wrong button held from preview into ESPERA is ignored
      botoes = 4'b0001;
      wait_st(4'h5, 80, "held_espera");
      tick(5);
      chk("held_ignored", 32'(db_estado), 'h5);
      chk("held_vidas", 32'(db_vidas), 'h2);
      chk("held_echo", 32'(leds), 'h1);
      botoes = 4'b0000;
      tick(2);
      jog(4'b0010);
      chk("held_m1", 32'(db_estado), 'h5);
      jog(4'b0100);
      chk("held_gera", 32'(db_estado), 'h2);

      // reset mid-preview
      wait_st(4'h3, 20, "mid_aceso");
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      chk("mid_rst_estado", 32'(db_estado), 'h0);
      chk("mid_rst_leds", 32'(leds), 'h0);
      chk("mid_rst_rodada", 32'(rodada), 'h0);
      chk("mid_rst_vidas", 32'(db_vidas), 'h0);
      chk("mid_rst_flags", 32'({ganhou, perdeu, timeout, pronto}), 'h0);
      tick(3);
      chk("mid_rst_idle", 32'(db_estado), 'h0);

      // seed 80 -> LFSR 80,01 -> sequence 0,1 (exercises the feedback taps)
      semente = 8'h80;
      start();
      tick(2);
      chk("seed_led", 32'(leds), 'h1);
      wait_st(4'h5, 60, "seed_espera");
      chk("seed_rodada", 32'(rodada), 'h1);
      chk("seed_vidas", 32'(db_vidas), 'h2);
      jog(4'b0001);
      chk("seed_gera", 32'(db_estado), 'h2);
      wait_st(4'h5, 80, "seed_r2");
      jog(4'b0001);
      chk("seed_m1", 32'(db_estado), 'h5);
      jog(4'b0010);
      chk("seed_r2_gera", 32'(db_estado), 'h2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
